punc_mem_responder: RTL
=======================

Name: punc_mem_responder

Overview:
- Word-addressed memory responder at the memory end of the PUnC control/datapath bus; services the controller's read/write strobes.
- Single-outstanding request/ready handshake with a configurable wait-state count, so the controller can be tested against slow memory.
- Includes a streaming preload port for loading program images before the processor leaves reset, plus a registered debug read port.

Parameters:
- DEPTH_LOG2, 8, log2 of word count (256 x 16-bit words).
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_rd  in  1  read request
- req_wr  in  1  write request
- req_addr  in  16  word address; only bits [DEPTH_LOG2-1:0] are used
- req_wdata  in  16  write data
- rsp_ready  out  1  one-cycle response strobe
- rsp_rdata  out  16  read data; valid while rsp_ready is high, held afterwards
- rsp_err  out  1  pulses with rsp_ready when req_rd and req_wr were both high at acceptance
- busy  out  1  high in every state except IDLE
- load_en  in  1  level; requests preload mode
- load_valid  in  1  preload data valid
- load_data  in  16  preload word
- load_ready  out  1  high in LOAD while not full
- load_count  out  DEPTH_LOG2+1  number of words written in the current or last load
- dbg_addr  in  DEPTH_LOG2  debug address
- dbg_data  out  16  registered mem[dbg_addr], one-cycle latency

Behaviour:
- States: IDLE, WAIT, RESP, LOAD.
- Reset values:
  - state = IDLE.
  - rsp_ready, rsp_err, busy, load_ready = 0.
  - rsp_rdata, dbg_data, load_count = 0.
  - Wait counter = 0.
  - Memory contents are not cleared.
- IDLE:
  - load_en = 1 has priority: go to LOAD and clear load_count.
  - Else, req_rd or req_wr high: latch address (modulo depth), wdata and op. If both are high, the op is a write and the error flag is latched.
  - Next state is WAIT with counter = WAIT_CYCLES-1, or RESP directly if WAIT_CYCLES = 0.
  - Requests are sampled only in IDLE.
- WAIT:
  - Counter decrements each cycle; leave to RESP when the counter is 0.
  - Request inputs are ignored.
- Commit point: on the clock edge entering RESP.
  - Write: mem[addr] <= wdata.
  - Read: rsp_rdata <= mem[addr].
  - On a write, rsp_rdata is unchanged.
- RESP:
  - Lasts exactly one cycle: rsp_ready = 1, rsp_err = latched flag. Then go to IDLE.
  - Initiator holds its request through RESP and drops it at the edge ending RESP. If the request is still high in IDLE, it is treated as a new request.
- Latency: request high in IDLE cycle T -> rsp_ready high in cycle T+1+WAIT_CYCLES.
- LOAD:
  - load_ready = 1 while load_count < DEPTH.
  - Each cycle with load_valid and load_ready: mem[load_count] <= load_data, then load_count++.
  - Once load_count = DEPTH: load_ready = 0 and further load_valid is ignored (no wrap).
  - load_en = 0: return to IDLE. load_count holds its final value until the next LOAD entry.
  - req_rd/req_wr are ignored in LOAD.
  - load_en rising while in WAIT or RESP is serviced after returning to IDLE.
- Debug port: dbg_data <= mem[dbg_addr] every cycle, in all states. A same-cycle write to the same address returns the old data.
- Reset mid-operation:
  - Return to IDLE.
  - A pending write that has not yet reached its commit edge is dropped.
  - No rsp_ready is issued.
  - Preload words already written are retained.
- Address wrap: req_addr 16'h0105 with DEPTH_LOG2 = 8 accesses word 8'h05.

Test Plan:
- Read latency, WAIT_CYCLES=1: preload mem[3]=16'h1234; req_rd, addr 3, in cycle T -> rsp_ready only in T+2, rsp_rdata=16'h1234, busy high in T+1 and T+2, rsp_err=0.
- Zero-wait write then read, WAIT_CYCLES=0: write 16'hBEEF to addr 7 -> rsp_ready at T+1; read addr 7 next -> rsp_rdata=16'hBEEF; dbg_addr=7 -> dbg_data=16'hBEEF one cycle later.
- Simultaneous rd and wr: wdata 16'h00AA, addr 2 -> treated as write; mem[2]=16'h00AA; rsp_err=1 together with rsp_ready; rsp_rdata unchanged.
- Preload: load_en=1, stream 5 words 16'h1000..16'h1004 with gaps in load_valid -> mem[0..4] written in order, load_count=5. Fill all 256 words -> load_ready=0; 257th word is ignored and mem[0] is unchanged.
- Reset mid-operation, WAIT_CYCLES=3: assert rst during WAIT of a write to addr 9 (old value 16'h0001) -> no rsp_ready, mem[9] stays 16'h0001, state returns to IDLE.
- Address wrap and busy-ignore: write to 16'h0105 -> mem[5] updated. A second request raised during WAIT is not accepted until IDLE.

Source files
------------

// File: rtl/punc_mem_responder.sv
// Word-addressed memory responder for the PUnC memory bus.
// One request in flight at a time, with a fixed number of wait states before
// the one-cycle response. A streaming preload port fills the memory from word
// 0 upward, and a registered debug port reads any word at any time.
//
// Handshake: a request (req_rd and/or req_wr) is sampled only in IDLE. It is
// answered by a single-cycle rsp_ready exactly WAIT_CYCLES+1 cycles later.
// Request inputs are ignored while busy. On the preload port, a word transfers
// on every rising edge where load_valid and load_ready are both high.
module punc_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [15:0]           req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_ready,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    input  logic                  load_en,
    input  logic                  load_valid,
    input  logic [15:0]           load_data,
    output logic                  load_ready,
    output logic [DEPTH_LOG2:0]   load_count,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [15:0]           dbg_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_COUNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, RESP, LOAD} state_t;

    state_t state, state_next;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [15:0]           wdata_q;
    logic                  wr_q;
    logic                  err_q;
    logic [3:0]            wait_cnt;

    logic                  accept;
    logic                  commit;
    logic                  load_fire;
    logic [DEPTH_LOG2-1:0] op_addr;
    logic [15:0]           op_wdata;
    logic                  op_wr;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [15:0]           mem_wdata;

    // Upper address bits are deliberately discarded: the address wraps modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[15:DEPTH_LOG2]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic, handshake outputs and memory write-port selection.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = (state != IDLE);
        rsp_ready  = (state == RESP);
        rsp_err    = (state == RESP) && err_q;
        load_ready = (state == LOAD) && (load_count < FULL_COUNT);
        load_fire  = load_ready && load_valid;
        case (state)
            IDLE: begin
                if (load_en) begin
                    state_next = LOAD;
                end else if (req_rd || req_wr) begin
                    accept     = 1'b1;
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            LOAD:    if (!load_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // With zero wait states the commit edge is the acceptance edge, so the
        // live request is used instead of the latched copy.
        op_addr   = (state == IDLE) ? req_addr[DEPTH_LOG2-1:0] : addr_q;
        op_wdata  = (state == IDLE) ? req_wdata : wdata_q;
        op_wr     = (state == IDLE) ? req_wr : wr_q;
        commit    = (state_next == RESP);
        mem_we    = !rst && ((commit && op_wr) || load_fire);
        mem_waddr = load_fire ? load_count[DEPTH_LOG2-1:0] : op_addr;
        mem_wdata = load_fire ? load_data : op_wdata;
    end

    // Latch the accepted request and run the wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= 4'd0;
        end else if (accept) begin
            addr_q   <= req_addr[DEPTH_LOG2-1:0];
            wdata_q  <= req_wdata;
            wr_q     <= req_wr;
            err_q    <= req_rd && req_wr;
            wait_cnt <= WAIT_INIT;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Preload word counter: cleared on LOAD entry, saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (rst)                         load_count <= '0;
        else if (state == IDLE && load_en) load_count <= '0;
        else if (load_fire)              load_count <= load_count + ONE_COUNT;
    end

    // Memory array: not reset, so preloaded words survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read data is captured on the edge entering RESP and held afterwards.
    always_ff @(posedge clk) begin
        if (rst)                  rsp_rdata <= '0;
        else if (commit && !op_wr) rsp_rdata <= mem[op_addr];
    end

    // Debug read port: old data is returned on a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) dbg_data <= '0;
        else     dbg_data <= mem[dbg_addr];
    end
endmodule
